// File: rtl/decode_queue_stage.sv
// F->D instruction queue: DEPTH-entry circular buffer with valid/ready on both
// sides, plus predecode of the head entry (register indices, immediate, pc+4).
module decode_queue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ILEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REGMSB = 5,
  parameter logic [ILEN-1:0] NOP = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            instr_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic                       pred_taken_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ILEN-1:0]            instr_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            pc_plus4_out,
  output logic                       pred_taken_out,
  output logic [REGMSB-1:0]          rs1_out,
  output logic [REGMSB-1:0]          rs2_out,
  output logic [REGMSB-1:0]          rd_out,
  output logic [XLEN-1:0]            imm_out,
  output logic                       illegal_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic            pred_q  [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic enq;
  logic deq;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != CW'(0));
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign count_out = count_q;

  // Pointer/occupancy next state; flush wins over any handshake.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_in) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pred_q[i]  <= 1'b0;
      end
    end else if (enq && !flush_in) begin
      instr_q[wptr_q] <= instr_in;
      pc_q[wptr_q]    <= pc_in;
      pred_q[wptr_q]  <= pred_taken_in;
    end
  end

  // Head view; empty queue presents a NOP at pc 0.
  assign instr_out      = out_valid ? instr_q[rptr_q] : NOP;
  assign pc_out         = out_valid ? pc_q[rptr_q]    : '0;
  assign pred_taken_out = out_valid & pred_q[rptr_q];
  assign pc_plus4_out   = pc_out + XLEN'(4);
  assign rs1_out        = REGMSB'(instr_out[19:15]);
  assign rs2_out        = REGMSB'(instr_out[24:20]);
  assign rd_out         = REGMSB'(instr_out[11:7]);

  logic [31:0] imm32;
  logic        bad_op;

  always_comb begin
    imm32  = '0;
    bad_op = 1'b0;
    case (instr_out[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm32 = {{20{instr_out[31]}}, instr_out[31:20]};
      OP_STORE:
        imm32 = {{20{instr_out[31]}}, instr_out[31:25], instr_out[11:7]};
      OP_BRANCH:
        imm32 = {{20{instr_out[31]}}, instr_out[7], instr_out[30:25],
                 instr_out[11:8], 1'b0};
      OP_JAL:
        imm32 = {{12{instr_out[31]}}, instr_out[19:12], instr_out[20],
                 instr_out[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {instr_out[31:12], 12'b0};
      OP_REG:
        imm32 = '0;
      default: begin
        imm32  = '0;
        bad_op = 1'b1;
      end
    endcase
  end

  assign imm_out     = XLEN'($signed(imm32));
  assign illegal_out = bad_op & out_valid;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: stimulus pushes expected head entries
// into a scoreboard, a negedge monitor pops and compares on each dequeue.
module tb_decode_queue_stage;

  logic        clk;
  logic        reset;
  logic        flush_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        pred_taken_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        pred_taken_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic        illegal_out;
  logic [2:0]  count_out;

  decode_queue_stage dut (
    .clk(clk), .reset(reset), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .pc_in(pc_in), .pred_taken_in(pred_taken_in),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .pred_taken_out(pred_taken_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .imm_out(imm_out), .illegal_out(illegal_out), .count_out(count_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] imm;
    logic        ill;
    logic        regs;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic pred, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.pred = pred; e.imm = imm; e.ill = ill;
    e.regs = 1'b0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    return e;
  endfunction

  // addi x1, x0, k  (k < 32): rd=1, rs1=0, rs2 field = k
  function automatic exp_t addi(input logic [4:0] k, input logic [31:0] pc, input logic pred);
    exp_t e;
    e = mk({7'd0, k, 5'd0, 3'd0, 5'd1, 7'h13}, pc, pred, {27'd0, k}, 1'b0);
    e.regs = 1'b1; e.rd = 5'd1; e.rs1 = 5'd0; e.rs2 = k;
    return e;
  endfunction

  // Called just after a posedge; presents one entry for one cycle.
  task automatic push(input exp_t e, output bit acc);
    in_valid = 1'b1; instr_in = e.instr; pc_in = e.pc; pred_taken_in = e.pred;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    if (acc && !flush_in) sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_instr"}, instr_out, 32'h00000013);
    chk({nm, "_pc"}, pc_out, 0);
    chk({nm, "_pc4"}, pc_plus4_out, 4);
    chk({nm, "_pred"}, pred_taken_out, 0);
    chk({nm, "_illegal"}, illegal_out, 0);
    chk({nm, "_imm"}, imm_out, 0);
    chk({nm, "_count"}, count_out, 0);
    chk({nm, "_regs"}, {rd_out, rs1_out, rs2_out}, 0);
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({nm, "_drained"}, sb.size(), 0);
    chk({nm, "_empty_after"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  // Monitor: a head is consumed at the next posedge when valid & ready & no flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && !flush_in && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", instr_out, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("head_instr", instr_out, e.instr);
          chk("head_pc", pc_out, e.pc);
          chk("head_pc4", pc_plus4_out, e.pc + 32'd4);
          chk("head_pred", pred_taken_out, e.pred);
          chk("head_imm", imm_out, e.imm);
          chk("head_illegal", illegal_out, e.ill);
          if (e.regs) begin
            chk("head_rd", rd_out, e.rd);
            chk("head_rs1", rs1_out, e.rs1);
            chk("head_rs2", rs2_out, e.rs2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_in = '0; pc_in = '0; pred_taken_in = 1'b0;
    #2;
    check_empty("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      push(addi(5'(i + 1), 32'(i * 4), i[0]), acc);
      chk("fill_accept", acc, 1);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count_out, 4);
    push(addi(5'd5, 32'h10, 1'b0), acc);
    chk("fifth_push_rejected", acc, 0);
    chk("full_count_after_reject", count_out, 4);
    drain("fill");

    // Steady push+pop at occupancy 2; pointers wrap several times.
    push(addi(5'd10, 32'h100, 1'b0), acc);
    push(addi(5'd11, 32'h104, 1'b1), acc);
    chk("pp_count_start", count_out, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(addi(5'(12 + i), 32'h108 + 32'(i * 4), i[1]), acc);
      chk("pp_count_steady", count_out, 2);
    end
    drain("pushpop");

    // Flush at count 3 with a simultaneous enqueue.
    for (int i = 0; i < 3; i++) push(addi(5'(20 + i), 32'h200 + 32'(i * 4), 1'b0), acc);
    chk("flush_pre_count", count_out, 3);
    flush_in = 1'b1;
    in_valid = 1'b1; instr_in = 32'h01F00093; pc_in = 32'h20C; pred_taken_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_empty("flush");
    @(posedge clk); #1;
    check_empty("flush_hold");
    push(addi(5'd30, 32'h300, 1'b1), acc);
    drain("post_flush");

    // Immediate decode through the queue at full throughput.
    out_ready = 1'b1;
    push(mk(32'hFFF00093, 32'h400, 1'b0, 32'hFFFFFFFF, 1'b0), acc);
    push(mk(32'hFE112E23, 32'h404, 1'b0, 32'hFFFFFFFC, 1'b0), acc);
    push(mk(32'hFE000EE3, 32'h408, 1'b1, 32'hFFFFFFFC, 1'b0), acc);
    push(mk(32'h0080006F, 32'h40C, 1'b1, 32'h00000008, 1'b0), acc);
    push(mk(32'h123452B7, 32'h410, 1'b0, 32'h12345000, 1'b0), acc);
    push(mk(32'h0000000B, 32'h414, 1'b0, 32'h00000000, 1'b1), acc);
    push(mk(32'h00B50533, 32'h418, 1'b0, 32'h00000000, 1'b0), acc);
    drain("imm");

    // Async reset mid-cycle at count 3.
    for (int i = 0; i < 3; i++) push(addi(5'(1 + i), 32'h500 + 32'(i * 4), 1'b1), acc);
    chk("areset_pre_count", count_out, 3);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check_empty("areset_immediate");
    @(posedge clk); #1;
    check_empty("areset_held");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_empty("areset_released");

    // pc+4 wraps modulo 2^32.
    push(addi(5'd7, 32'hFFFFFFFC, 1'b0), acc);
    chk("wrap_pc", pc_out, 32'hFFFFFFFC);
    chk("wrap_pc4", pc_plus4_out, 32'h00000000);
    drain("wrap");

    chk("sb_final_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
Parametrised successor to the single-register F->D pipeline latch: a DEPTH-entry instruction queue between fetch and decode with valid/ready handshakes on both sides. It also predecodes the head entry, producing register indices, the sign-extended immediate, pc+4 and an illegal-opcode flag. This lets fetch run ahead of decode stalls without refetching. Flush empties the queue in one cycle.

Parameters:
XLEN, 32, data/PC width
ILEN, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
REGMSB, 5, register index width
NOP, 32'h00000013, instruction presented while the queue is empty

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
flush_in  in  1  synchronous flush; empties queue
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept (~full)
instr_in  in  ILEN  fetched instruction
pc_in  in  XLEN  PC of instr_in
pred_taken_in  in  1  branch prediction for instr_in
out_valid  out  1  head entry valid (~empty)
out_ready  in  1  decode consumes the head (~stall)
instr_out  out  ILEN  head instruction, or NOP when empty
pc_out  out  XLEN  head PC, or 0 when empty
pc_plus4_out  out  XLEN  pc_out + 4, modulo 2^XLEN
pred_taken_out  out  1  head prediction, or 0 when empty
rs1_out / rs2_out / rd_out  out  REGMSB  instr_out[19:15] / [24:20] / [11:7]
imm_out  out  XLEN  immediate of the head instruction
illegal_out  out  1  head opcode unsupported (valid only when out_valid)
count_out  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: circular buffer with write pointer, read pointer and count registers. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (reset=0, asynchronous): pointers=0, count=0, all entries cleared. Outputs follow the empty state: out_valid=0, in_ready=1, instr_out=NOP, pc_out=0, pc_plus4_out=4, pred_taken_out=0, illegal_out=0, imm_out=0. Reset asserted mid-operation discards everything immediately.
- in_ready = (count != DEPTH). out_valid = (count != 0). Both are combinational from registers only; neither depends on in_valid or out_ready.
- Enqueue fires on in_valid & in_ready: writes {instr_in, pc_in, pred_taken_in} at wptr, then wptr++.
- Dequeue fires on out_valid & out_ready: rptr++.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Full: in_ready=0 even if a dequeue fires that cycle. The input is dropped by fetch and retried next cycle.
- Empty: no bypass. An entry enqueued in cycle N is first visible on the outputs in cycle N+1.
- Flush (posedge with flush_in=1): pointers=0, count=0. Overrides enqueue and dequeue in the same cycle. From the next cycle the queue is empty, and the outputs show the NOP/empty state.
- Head outputs are combinational from the entry at rptr. When empty they are forced to NOP / 0 / 0.
- Immediate by opcode instr_out[6:0], all sign-extended from bit 31:
  - I-type: 0010011, 0000011, 1100111 -> {20{i[31]}, i[31:20]}
  - S-type: 0100011 -> {i[31:25], i[11:7]}
  - B-type: 1100011 -> {i[7], i[30:25], i[11:8], 0}
  - J-type: 1101111 -> {i[19:12], i[20], i[30:21], 0}
  - U-type: 0110111, 0010111 -> {i[31:12], 12'b0}, no sign extension
  - R-type: 0110011 -> imm 0
  - Any other opcode: imm 0 and illegal_out=1.
- illegal_out is gated with out_valid, so it is never set for the empty-state NOP.
- No X on any output in any state.

Test Plan:
- Reset, then fill: hold out_ready=0 and push 4 instructions with pc 0x0,0x4,0x8,0xC. After the 4th, in_ready=0 and count_out=4. A 5th push is not accepted. Then set out_ready=1: outputs appear in order 0x0..0xC, out_valid drops after the 4th, and pc_plus4_out tracks pc+4 throughout.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, pointers wrap past 3, and FIFO order is preserved.
- Flush at count=3 with an enqueue in the same cycle: next cycle count_out=0, out_valid=0, instr_out=0x00000013, and the flushed-cycle instruction is absent.
- Immediates:
  - 0xFFF00093 -> imm 0xFFFFFFFF
  - 0xFE112E23 -> imm 0xFFFFFFFC
  - 0xFE000EE3 (beq) -> imm 0xFFFFFFFC
  - 0x0080006F -> imm 0x00000008
  - 0x123452B7 -> imm 0x12345000
  - 0x0000000B -> illegal_out=1, imm 0
- Async reset asserted mid-cycle at count=3: outputs drop to the empty state immediately, before the next clock edge, and stay there until reset is released.
- pc wrap: pc_in=0xFFFFFFFC -> pc_plus4_out=0x00000000.
